bell_referee: RTL and testbench
===============================

# bell_referee

N-player bell-game referee: arbitrates simultaneous bell presses, judges the displayed card pair, and updates a per-player signed score file. It declares a match winner once one player leads all others by a configurable margin. It replaces the fixed two-player press/judge/score chain and sits between the keypad decoder (which supplies per-player `press` lines) and the LED/7-segment display logic.

## Interface
Parameters:
- `NUM_PLAYERS`, 4: player count, 2..8.
- `SCORE_W`, 8: signed score width per player; also the width of `pot`.
- `NUM_W`, 3: card number width.
- `COLOR_W`, 2: card colour width.
- `TARGET`, 5: required number or number sum.
- `LEAD_MARGIN`, 9: winning lead (strictly greater than).
- `HOLD_CYCLES`, 4: minimum post-round lockout, ≥1.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `press`  in  NUM_PLAYERS: per-player bell request, level.
- `card_valid`  in  1: card pair below is valid.
- `c_a`, `c_b`  in  COLOR_W: card colours.
- `n_a`, `n_b`  in  NUM_W: card numbers.
- `pot`  in  SCORE_W: unsigned reward for a correct press.
- `scores`  out  NUM_PLAYERS*SCORE_W: player i at `[i*SCORE_W +: SCORE_W]`, two's complement.
- `grant_id`  out  3: last granted player.
- `round_done`  out  1: one-cycle pulse after scores update.
- `last_right`  out  1: judgement of the last round.
- `game_over`  out  1: sticky.
- `winner_id`  out  3: valid while `game_over` is high.

## Operation
- FSM states:
  - IDLE → JUDGE when `card_valid && |press && !game_over`.
  - JUDGE → AWARD unconditionally.
  - AWARD → HOLD unconditionally.
  - HOLD → IDLE when the hold counter is 0 and `press == 0`.
- Arbitration: round-robin starting at `rr_ptr`; the first asserted `press` bit at or after `rr_ptr` (mod N) wins. On IDLE→JUDGE, capture grant, `c_a/c_b/n_a/n_b` and `pot`. `rr_ptr` becomes `(grant+1) mod N` when HOLD is entered.
- Judgement in JUDGE, registered into `last_right`:
  - Equal colours: right iff `n_a+n_b == TARGET`, computed in NUM_W+1 bits.
  - Different colours: right iff `n_a == TARGET || n_b == TARGET`.
- AWARD:
  - Right: `scores[grant] += pot`.
  - Wrong: penalty per Configuration.
  - All additions are signed and saturate to [-2^(SCORE_W-1), 2^(SCORE_W-1)-1]. `pot` is zero-extended.
- Winner check on the first HOLD cycle: the maximum score, lowest index on ties, must exceed every other score + LEAD_MARGIN, compared in SCORE_W+1 bits. If so, set `game_over` and `winner_id`. Both hold until reset.
- Ignored inputs:
  - `press` outside IDLE (no queueing).
  - `press` with `card_valid` low.
  - Everything after `game_over`.
- A press held across HOLD cannot retrigger; all lines must drop first.

## Timing
- Press seen in IDLE at cycle t:
  - JUDGE at t+1; `grant_id` is valid from t+1.
  - AWARD at t+2; `last_right` is valid from t+2.
  - New `scores` and the `round_done` pulse at t+3.
  - `game_over` at t+4 if the margin is met.
- HOLD lasts at least HOLD_CYCLES cycles. The earliest next grant is sampled at t+3+HOLD_CYCLES.
- Reset, also mid-round: at the next edge, state=IDLE, all scores=0, `rr_ptr`=0, hold counter=0. All outputs read 0.

## Configuration
- `BELL_PENALTY_EN`:
  - Defined: a wrong press makes `scores[grant] -= (NUM_PLAYERS-1)` and every other player +1, all saturating.
  - Undefined: a wrong press changes no score. `round_done` still pulses and `last_right` still reads 0.

## Structure
- Package `bell_pkg` holds:
  - The state enum (IDLE, JUDGE, AWARD, HOLD).
  - The `sat_add` signed saturating function.
  - The `is_match` card-judgement function.
  - Default parameter constants.
- Sub-module `bell_rr_arbiter`: NUM_PLAYERS requests plus pointer in, one-hot grant and index out, combinational. The pointer register stays in `bell_referee`.

## Test plan
- Defaults with `BELL_PENALTY_EN`. After reset, card (c0,2)/(c0,3), `pot`=7, `press`=0100 at t. Expect `grant_id`=2 at t+1, scores {0,0,7,0} and `round_done` at t+3.
- Continue. Card (c0,5)/(c1,1), `press`=1010 together, `rr_ptr`=3. Expect player 3 granted, `scores[3]`=7.
- Wrong press: card (c1,2)/(c1,2), player 0 presses. With the macro, scores {-3,1,1,1}. Without it, scores are unchanged and `last_right`=0.
- Saturation: `scores[1]`=120, `pot`=20, correct press → `scores[1]`=127. At -127 with a wrong press → -128.
- Winner: scores {0,10,0,0} after an award → `game_over`=1, `winner_id`=1 at t+4. Further presses cause no grant.
- `press`=0001 held for 20 cycles gives exactly one round. Reset asserted during JUDGE → all zero next cycle, no `round_done`.

Source files
------------

// File: rtl/bell_pkg.sv
// Shared types, default constants and scoring/judging helpers for the bell_referee slice.
package bell_pkg;

    localparam int unsigned DefNumPlayers = 4;
    localparam int unsigned DefScoreW     = 8;
    localparam int unsigned DefNumW       = 3;
    localparam int unsigned DefColorW     = 2;
    localparam int unsigned DefTarget     = 5;
    localparam int unsigned DefLeadMargin = 9;
    localparam int unsigned DefHoldCycles = 4;

    typedef enum logic [1:0] {StIdle, StJudge, StAward, StHold} state_e;

    // Signed add clamped to the range of a w-bit two's complement value.
    function automatic int sat_add(input int a, input int b, input int unsigned w);
        int hi;
        int lo;
        int s;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        s  = a + b;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    function automatic logic is_match(input logic same_color, input int a, input int b,
                                      input int target);
        if (same_color) return (a + b) == target;
        return (a == target) || (b == target);
    endfunction

endpackage

// File: rtl/bell_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer, modulo NumReq.
module bell_rr_arbiter #(
    parameter int unsigned NumReq = 4
) (
    input  logic [NumReq-1:0] i_req,
    input  logic [2:0]        i_ptr,
    output logic [NumReq-1:0] o_grant_oh,
    output logic [2:0]        o_grant_idx
);

    localparam int unsigned PosW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [PosW-1:0] w_pos;
    logic            w_found;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_pos       = '0;
        w_found     = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            w_pos = PosW'((int'(i_ptr) + i) % NumReq);
            if (!w_found && i_req[w_pos]) begin
                w_found           = 1'b1;
                o_grant_oh[w_pos] = 1'b1;
                o_grant_idx       = 3'(w_pos);
            end
        end
    end

endmodule

// File: rtl/bell_referee.sv
// N-player bell-game referee: arbitration, card judgement, saturating score file, winner latch.
// Define BELL_PENALTY_EN to penalise wrong presses (grant loses N-1, every other player gains 1).
module bell_referee
    import bell_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = DefNumPlayers,
    parameter int unsigned SCORE_W     = DefScoreW,
    parameter int unsigned NUM_W       = DefNumW,
    parameter int unsigned COLOR_W     = DefColorW,
    parameter int unsigned TARGET      = DefTarget,
    parameter int unsigned LEAD_MARGIN = DefLeadMargin,
    parameter int unsigned HOLD_CYCLES = DefHoldCycles
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PLAYERS-1:0]         press,
    input  logic                           card_valid,
    input  logic [COLOR_W-1:0]             c_a,
    input  logic [COLOR_W-1:0]             c_b,
    input  logic [NUM_W-1:0]               n_a,
    input  logic [NUM_W-1:0]               n_b,
    input  logic [SCORE_W-1:0]             pot,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [2:0]                     grant_id,
    output logic                           round_done,
    output logic                           last_right,
    output logic                           game_over,
    output logic [2:0]                     winner_id
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_e                    r_state;
    logic [2:0]                r_rr_ptr;
    logic [2:0]                r_grant;
    logic [COLOR_W-1:0]        r_c_a, r_c_b;
    logic [NUM_W-1:0]          r_n_a, r_n_b;
    logic [SCORE_W-1:0]        r_pot;
    logic [HoldW-1:0]          r_hold_cnt;
    logic                      r_round_done;
    logic                      r_last_right;
    logic                      r_game_over;
    logic [2:0]                r_winner;
    logic signed [SCORE_W-1:0] r_score [NUM_PLAYERS];

    logic [NUM_PLAYERS-1:0]    w_grant_oh;
    logic [2:0]                w_grant_idx;
    logic signed [SCORE_W-1:0] w_award [NUM_PLAYERS];
    logic signed [SCORE_W-1:0] w_max_val;
    logic [2:0]                w_max_idx;
    logic signed [SCORE_W:0]   w_lhs, w_rhs;
    logic                      w_lead_ok;

    bell_rr_arbiter #(
        .NumReq (NUM_PLAYERS)
    ) u_arb (
        .i_req       (press),
        .i_ptr       (r_rr_ptr),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            w_award[i] = r_score[i];
            if (r_last_right) begin
                if (i == int'(r_grant)) begin
                    w_award[i] = SCORE_W'(sat_add(int'(r_score[i]), int'(r_pot), SCORE_W));
                end
            end
`ifdef BELL_PENALTY_EN
            else if (i == int'(r_grant)) begin
                w_award[i] = SCORE_W'(sat_add(int'(r_score[i]), 1 - int'(NUM_PLAYERS), SCORE_W));
            end else begin
                w_award[i] = SCORE_W'(sat_add(int'(r_score[i]), 1, SCORE_W));
            end
`endif
        end
    end

    // Leader is the lowest-index maximum; it must beat every other score plus the margin.
    always_comb begin
        w_max_idx = '0;
        w_max_val = r_score[0];
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if (r_score[i] > w_max_val) begin
                w_max_val = r_score[i];
                w_max_idx = 3'(i);
            end
        end
        w_lhs     = {w_max_val[SCORE_W-1], w_max_val};
        w_rhs     = '0;
        w_lead_ok = 1'b1;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            if (3'(j) != w_max_idx) begin
                w_rhs = {r_score[j][SCORE_W-1], r_score[j]} + (SCORE_W + 1)'(LEAD_MARGIN);
                if (w_lhs <= w_rhs) w_lead_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_c_a        <= '0;
            r_c_b        <= '0;
            r_n_a        <= '0;
            r_n_b        <= '0;
            r_pot        <= '0;
            r_hold_cnt   <= '0;
            r_round_done <= 1'b0;
            r_last_right <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
        end else begin
            r_round_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (card_valid && |w_grant_oh && !r_game_over) begin
                        r_state <= StJudge;
                        r_grant <= w_grant_idx;
                        r_c_a   <= c_a;
                        r_c_b   <= c_b;
                        r_n_a   <= n_a;
                        r_n_b   <= n_b;
                        r_pot   <= pot;
                    end
                end
                StJudge: begin
                    r_last_right <= is_match(r_c_a == r_c_b, int'(r_n_a), int'(r_n_b),
                                             int'(TARGET));
                    r_state      <= StAward;
                end
                StAward: begin
                    for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= w_award[i];
                    r_round_done <= 1'b1;
                    r_rr_ptr     <= (r_grant == 3'(NUM_PLAYERS - 1)) ? 3'd0 : r_grant + 3'd1;
                    r_hold_cnt   <= HoldW'(HOLD_CYCLES - 1);
                    r_state      <= StHold;
                end
                StHold: begin
                    // round_done is high exactly on the first HOLD cycle
                    if (r_round_done && w_lead_ok) begin
                        r_game_over <= 1'b1;
                        r_winner    <= w_max_idx;
                    end
                    if (r_hold_cnt == '0) begin
                        if (press == '0) r_state <= StIdle;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        scores = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) scores[i*SCORE_W +: SCORE_W] = r_score[i];
    end

    assign grant_id   = r_grant;
    assign round_done = r_round_done;
    assign last_right = r_last_right;
    assign game_over  = r_game_over;
    assign winner_id  = r_winner;

endmodule

// File: tb/tb_bell_referee.sv
// Scoreboard bench for bell_referee; the reference model follows BELL_PENALTY_EN like the DUT.
module tb_bell_referee;

    localparam int NP   = 4;
    localparam int SW   = 8;
    localparam int TGT  = 5;
    localparam int MARG = 9;
    localparam int HOLD = 4;

    typedef struct packed {
        logic [2:0]       grant;
        logic             right;
        logic [NP*SW-1:0] sc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [NP-1:0]    press;
    logic             card_valid;
    logic [1:0]       c_a, c_b;
    logic [2:0]       n_a, n_b;
    logic [SW-1:0]    pot;
    logic [NP*SW-1:0] scores;
    logic [2:0]       grant_id;
    logic             round_done;
    logic             last_right;
    logic             game_over;
    logic [2:0]       winner_id;

    int   n_checks;
    int   n_fail;
    int   n_done;
    exp_t sb_q[$];
    exp_t sb_e;
    int   m_score [NP];
    int   m_ptr;
    bit   m_over;
    int   m_winner;

    bell_referee #(
        .NUM_PLAYERS (NP),
        .SCORE_W     (SW),
        .NUM_W       (3),
        .COLOR_W     (2),
        .TARGET      (TGT),
        .LEAD_MARGIN (MARG),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .press      (press),
        .card_valid (card_valid),
        .c_a        (c_a),
        .c_b        (c_b),
        .n_a        (n_a),
        .n_b        (n_b),
        .pot        (pot),
        .scores     (scores),
        .grant_id   (grant_id),
        .round_done (round_done),
        .last_right (last_right),
        .game_over  (game_over),
        .winner_id  (winner_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sc(input int i);
        return int'($signed(scores[i*SW +: SW]));
    endfunction

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_score[i] = 0;
        m_ptr    = 0;
        m_over   = 1'b0;
        m_winner = 0;
    endtask

    task automatic model_round(input logic [NP-1:0] p, input int ca, input int na, input int cb,
                               input int nb, input int pv, output int g, output bit right);
        exp_t e;
        int   mx;
        bit   lead;
        g = -1;
        for (int i = 0; i < NP; i++) begin
            if (g < 0 && p[(m_ptr + i) % NP]) g = (m_ptr + i) % NP;
        end
        right = (ca == cb) ? ((na + nb) == TGT) : (na == TGT || nb == TGT);
        if (right) begin
            m_score[g] = sat8(m_score[g] + pv);
        end else begin
`ifdef BELL_PENALTY_EN
            for (int i = 0; i < NP; i++)
                m_score[i] = (i == g) ? sat8(m_score[i] - (NP - 1)) : sat8(m_score[i] + 1);
`endif
        end
        m_ptr = (g + 1) % NP;
        if (!m_over) begin
            mx = 0;
            for (int i = 1; i < NP; i++) if (m_score[i] > m_score[mx]) mx = i;
            lead = 1'b1;
            for (int j = 0; j < NP; j++) if (j != mx && !(m_score[mx] > m_score[j] + MARG)) lead = 0;
            if (lead) begin
                m_over   = 1'b1;
                m_winner = mx;
            end
        end
        e.grant = 3'(g);
        e.right = right;
        for (int i = 0; i < NP; i++) e.sc[i*SW +: SW] = 8'(m_score[i]);
        sb_q.push_back(e);
    endtask

    // Waits gap negedges, drives one press cycle, then checks the per-stage timing up to t+4.
    task automatic run_round(input logic [NP-1:0] p, input int ca, input int na, input int cb,
                             input int nb, input int pv, input int gap);
        int g;
        bit right;
        repeat (gap) @(negedge clk);
        @(posedge clk); #1;
        press      = p;
        card_valid = 1'b1;
        c_a        = 2'(ca);
        n_a        = 3'(na);
        c_b        = 2'(cb);
        n_b        = 3'(nb);
        pot        = 8'(pv);
        model_round(p, ca, na, cb, nb, pv, g, right);
        @(posedge clk); #1;
        press      = '0;
        card_valid = 1'b0;
        @(negedge clk);
        check_val("grant_t1", int'(grant_id), g);
        @(negedge clk);
        check_val("right_t2", int'(last_right), int'(right));
        @(negedge clk);
        check_val("done_t3", int'(round_done), 1);
        @(negedge clk);
        check_val("done_pulse", int'(round_done), 0);
        check_val("over_t4", int'(game_over), int'(m_over));
        if (m_over) check_val("winner_t4", int'(winner_id), m_winner);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst        = 1'b0;
        press      = '0;
        card_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (round_done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_done", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                check_val("sb_grant", int'(grant_id), int'(sb_e.grant));
                check_val("sb_right", int'(last_right), int'(sb_e.right));
                for (int i = 0; i < NP; i++)
                    check_val("sb_score", sc(i), int'($signed(sb_e.sc[i*SW +: SW])));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        n_checks   = 0;
        n_fail     = 0;
        n_done     = 0;
        rst        = 1'b0;
        press      = '0;
        card_valid = 1'b0;
        c_a        = '0;
        c_b        = '0;
        n_a        = '0;
        n_b        = '0;
        pot        = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_val("rst_scores", int'(scores != '0), 0);
        check_val("rst_grant", int'(grant_id), 0);
        check_val("rst_done", int'(round_done), 0);
        check_val("rst_right", int'(last_right), 0);
        check_val("rst_over", int'(game_over), 0);
        check_val("rst_winner", int'(winner_id), 0);

        // Equal colours summing to target, single presser.
        run_round(4'b0100, 0, 2, 0, 3, 7, 0);
        check_val("a_s2", sc(2), 7);
        check_val("a_s0", sc(0), 0);
        // Two pressers, pointer at 3 after player 2 won.
        run_round(4'b1010, 0, 5, 1, 1, 7, HOLD);
        check_val("b_grant", int'(grant_id), 3);
        check_val("b_s3", sc(3), 7);
        // Wrong press issued at the earliest legal cycle after the previous round.
        run_round(4'b0001, 1, 2, 1, 2, 7, HOLD - 2);
        check_val("w_right", int'(last_right), 0);
`ifdef BELL_PENALTY_EN
        check_val("w_s0", sc(0), -3);
        check_val("w_s1", sc(1), 1);
`else
        check_val("w_s0", sc(0), 0);
        check_val("w_s1", sc(1), 0);
`endif

        // A press in the last HOLD cycle is ignored and must drop before the next round.
        snap = n_done;
        @(posedge clk); #1;
        @(posedge clk); #1;
        press      = 4'b0010;
        card_valid = 1'b1;
        @(posedge clk); #1;
        press      = '0;
        card_valid = 1'b0;
        repeat (8) @(negedge clk);
        check_val("hold_press_ignored", n_done - snap, 0);

        // Reset while in JUDGE.
        @(posedge clk); #1;
        press      = 4'b0001;
        card_valid = 1'b1;
        c_a        = 2'd0;
        n_a        = 3'd5;
        @(posedge clk); #1;
        press      = '0;
        card_valid = 1'b0;
        rst        = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_val("mid_rst_scores", int'(scores != '0), 0);
        check_val("mid_rst_right", int'(last_right), 0);
        check_val("mid_rst_grant", int'(grant_id), 0);
        snap = n_done;
        repeat (6) @(negedge clk);
        check_val("mid_rst_no_done", n_done - snap, 0);

        // Positive saturation: everyone climbs to 120 without a winner, then +20 on player 1.
        do_reset();
        for (int k = 0; k < 60; k++) run_round(4'b1111, 0, 2, 0, 3, 8, HOLD);
        run_round(4'b0010, 0, 2, 0, 3, 20, HOLD);
        check_val("sat_hi", sc(1), 127);
        check_val("sat_hi_other", sc(0), 120);

        // Negative saturation through repeated wrong presses by player 0.
        do_reset();
        for (int k = 0; k < 43; k++) run_round(4'b0001, 1, 2, 1, 2, 9, HOLD);
`ifdef BELL_PENALTY_EN
        check_val("sat_lo", sc(0), -128);
        check_val("sat_lo_other", sc(1), 43);
`else
        check_val("sat_lo", sc(0), 0);
        check_val("sat_lo_other", sc(1), 0);
`endif

        // Winner by a lead of 10 over a margin of 9; afterwards presses are ignored.
        do_reset();
        run_round(4'b0010, 0, 5, 1, 0, 10, 0);
        repeat (HOLD) @(negedge clk);
        snap = n_done;
        @(posedge clk); #1;
        press      = 4'b1111;
        card_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        press      = '0;
        card_valid = 1'b0;
        repeat (6) @(negedge clk);
        check_val("over_no_round", n_done - snap, 0);
        check_val("over_sticky", int'(game_over), 1);
        check_val("over_winner", int'(winner_id), 1);
        check_val("over_grant", int'(grant_id), 1);

        // A press held for 20 cycles yields exactly one round.
        do_reset();
        snap = n_done;
        begin
            int g;
            bit right;
            @(posedge clk); #1;
            press      = 4'b0001;
            card_valid = 1'b1;
            c_a        = 2'd0;
            n_a        = 3'd5;
            c_b        = 2'd1;
            n_b        = 3'd0;
            pot        = 8'd1;
            model_round(4'b0001, 0, 5, 1, 0, 1, g, right);
        end
        repeat (20) @(posedge clk);
        #1;
        press      = '0;
        card_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_val("held_one_round", n_done - snap, 1);
        check_val("held_s0", sc(0), 1);

        check_val("sb_drain", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
